decode_stage: RTL and testbench

//   MIPS ID stage, directly downstream of fetch. Holds the IF/ID pipeline register and the 32x32 register file.

---
 rtl/decode_stage.sv | 94 +++++++++
 tb/tb_decode_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with IF/ID register, 32x32 register file and BEQ/BNE resolution
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall, flush        hold / squash the IF/ID register (flush wins)
//   if_instruction,     instruction and PC+4 from fetch
//   if_pc_plus4
//   wb_we, wb_addr,     register-file write port from WB
//   wb_data
//   id_valid, id_instruction, id_pc_plus4        IF/ID register contents
//   opcode, funct, rs, rt, rd, shamt             decoded instruction fields
//   rs_data, rt_data    register reads with write-first bypass
//   imm_ext             zero-extended for ANDI/ORI/XORI, sign-extended otherwise
//   branch_target, pcsrc  branch address and taken flag returned to fetch
module decode_stage #(
    parameter int                DATA_W = 32,
    parameter int                REG_AW = 5,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic [DATA_W-1:0] if_pc_plus4,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [DATA_W-1:0] id_pc_plus4,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] branch_target,
    output logic              pcsrc
);
    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rf [2**REG_AW];
    logic [15:0]       w_imm;
    logic              w_zext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_pc4   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_pc4   <= '0;
        end else if (!stall) begin
            r_valid <= 1'b1;
            r_instr <= if_instruction;
            r_pc4   <= if_pc_plus4;
        end
    end

    // Entry 0 is cleared on reset and never written, so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) r_rf[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    assign id_valid       = r_valid;
    assign id_instruction = r_instr;
    assign id_pc_plus4    = r_pc4;
    assign opcode         = r_instr[31:26];
    assign rs             = r_instr[25:21];
    assign rt             = r_instr[20:16];
    assign rd             = r_instr[15:11];
    assign shamt          = r_instr[10:6];
    assign funct          = r_instr[5:0];
    assign w_imm          = r_instr[15:0];

    // Write-first bypass lets an instruction in ID see the value WB is writing this cycle.
    assign rs_data = (wb_we && wb_addr == rs && rs != '0) ? wb_data : r_rf[rs];
    assign rt_data = (wb_we && wb_addr == rt && rt != '0) ? wb_data : r_rf[rt];

    assign w_zext        = opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E;
    assign imm_ext       = w_zext ? {{(DATA_W-16){1'b0}}, w_imm} : {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign branch_target = r_pc4 + (imm_ext << 2);
    assign pcsrc         = r_valid && ((opcode == 6'h04 && rs_data == rt_data) ||
                                       (opcode == 6'h05 && rs_data != rt_data));
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed scoreboard bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b1;
    logic        rst, stall, flush, wb_we;
    logic [31:0] if_instruction, if_pc_plus4, wb_data;
    logic [4:0]  wb_addr;
    logic        id_valid, pcsrc;
    logic [31:0] id_instruction, id_pc_plus4, rs_data, rt_data, imm_ext, branch_target;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;

    decode_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_instruction(id_instruction), .id_pc_plus4(id_pc_plus4),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .branch_target(branch_target), .pcsrc(pcsrc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] ins, pc4, rsd, rtd, imm, bt;
        logic        pc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_ins, m_pc4;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!rst && wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic exp_t model_out();
        exp_t        e;
        logic [5:0]  op;
        logic [15:0] im;
        op    = m_ins[31:26];
        im    = m_ins[15:0];
        e.v   = m_valid;
        e.ins = m_ins;
        e.pc4 = m_pc4;
        e.rsd = rd_reg(m_ins[25:21]);
        e.rtd = rd_reg(m_ins[20:16]);
        e.imm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? 32'(im) : 32'($signed(im));
        e.bt  = m_pc4 + e.imm * 4;
        e.pc  = m_valid && ((op == 6'h04 && e.rsd == e.rtd) || (op == 6'h05 && e.rsd != e.rtd));
        return e;
    endfunction

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        m_ins   = 32'h0;
        m_pc4   = 32'h0;
    endfunction

    function automatic void model_clock();
        if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
        if (flush) begin
            m_valid = 1'b0;
            m_ins   = 32'h0;
            m_pc4   = 32'h0;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_ins   = if_instruction;
            m_pc4   = if_pc_plus4;
        end
    endfunction

    task automatic cyc();
        q.push_back(model_out());
        @(posedge clk);
        if (!rst) model_clock();
        #1;
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] pc4, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_instruction = ins;
        if_pc_plus4    = pc4;
        stall          = st;
        flush          = fl;
        wb_we          = we;
        wb_addr        = wa;
        wb_data        = wd;
        cyc();
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                       input logic [15:0] im);
        return {op, a, b, im};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("id_valid", 32'(id_valid), 32'(e.v));
                chk("id_instruction", id_instruction, e.ins);
                chk("fields", {opcode, rs, rt, rd, shamt, funct}, e.ins);
                chk("id_pc_plus4", id_pc_plus4, e.pc4);
                chk("rs_data", rs_data, e.rsd);
                chk("rt_data", rt_data, e.rtd);
                chk("imm_ext", imm_ext, e.imm);
                chk("branch_target", branch_target, e.bt);
                chk("pcsrc", 32'(pcsrc), 32'(e.pc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h23};
        rst = 1'b1;
        model_reset();
        drv(32'h0, 32'h0, 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) drv(mk(6'h00, 5'(i), 5'(i), 16'h0), 32'(i * 4), 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 1, 5'd8, 32'hDEADBEEF);
        drv(mk(6'h08, 5'd8, 5'd0, 16'h0), 32'h10, 0, 0, 1, 5'd0, 32'h1234);
        drv(mk(6'h08, 5'd0, 5'd9, 16'h0), 32'h14, 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 1, 5'd9, 32'hCAFE);
        drv(mk(6'h23, 5'd8, 5'd9, 16'h0004), 32'h100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drv($urandom, $urandom, 1, 0, 0, 0, 0);
        drv($urandom, $urandom, 1, 1, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 1, 5'd8, 32'd5);
        drv(32'h0, 32'h0, 0, 0, 1, 5'd9, 32'd5);
        drv(32'h1109FFFE, 32'h40, 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 1, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 1, 0, 1, 5'd9, 32'd6);
        drv(32'h1509FFFE, 32'h40, 0, 0, 0, 0, 0);
        drv(mk(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h44, 0, 0, 0, 0, 0);
        drv(mk(6'h08, 5'd0, 5'd1, 16'h8000), 32'h48, 0, 0, 0, 0, 0);
        drv(mk(6'h04, 5'd0, 5'd0, 16'h0001), 32'hFFFFFFFC, 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            drv(mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)),
                $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 1'($urandom),
                5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
        drv(32'h1109FFFE, 32'h40, 0, 0, 0, 0, 0);
        wb_we   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h55;
        rst     = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
        for (int i = 1; i < 4; i++) drv(mk(6'h05, 5'(i), 5'd0, 16'h0), 32'h0, 0, 0, 0, 0, 0);
        drv(32'h0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
